// File: rtl/wb_pipe.sv
// Result-path pipeline from execute to the register file write port.
// Tracks valid entries, supports stall/flush, youngest-first forwarding and retire counting.
module wb_pipe #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned STAGES = 3,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic                       in_rd_ena_i,
    input  logic [ADDR_W-1:0]          in_rd_addr_i,
    input  logic [DATA_W-1:0]          in_rd_data_i,
    input  logic                       stall_i,
    input  logic                       flush_i,
    output logic                       w_ena_o,
    output logic [ADDR_W-1:0]          w_addr_o,
    output logic [DATA_W-1:0]          w_data_o,
    input  logic [NUM_RD*ADDR_W-1:0]   rs_addr_i,
    output logic [NUM_RD-1:0]          fwd_hit_o,
    output logic [NUM_RD*DATA_W-1:0]   fwd_data_o,
    output logic [3:0]                 occupancy_o,
    output logic [CNT_W-1:0]           retired_o
);

    localparam int unsigned Old = STAGES - 1;

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] rd_ena_q;
    logic [ADDR_W-1:0] rd_addr_q [STAGES];
    logic [DATA_W-1:0] rd_data_q [STAGES];
    logic [CNT_W-1:0]  retired_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q   <= '0;
            rd_ena_q  <= '0;
            retired_q <= '0;
            for (int k = 0; k < int'(STAGES); k++) begin
                rd_addr_q[k] <= '0;
                rd_data_q[k] <= '0;
            end
        end else begin
            if (w_ena_o) begin
                retired_q <= retired_q + CNT_W'(1);
            end
            // Flush only clears valid; stale data is masked everywhere by valid.
            if (flush_i) begin
                valid_q <= '0;
            end else if (!stall_i) begin
                valid_q[0]   <= in_valid_i;
                rd_ena_q[0]  <= in_rd_ena_i;
                rd_addr_q[0] <= in_rd_addr_i;
                rd_data_q[0] <= in_rd_data_i;
                for (int k = 1; k < int'(STAGES); k++) begin
                    valid_q[k]   <= valid_q[k-1];
                    rd_ena_q[k]  <= rd_ena_q[k-1];
                    rd_addr_q[k] <= rd_addr_q[k-1];
                    rd_data_q[k] <= rd_data_q[k-1];
                end
            end
        end
    end

    assign in_ready_o = !stall_i;
    assign retired_o  = retired_q;
    assign w_ena_o    = valid_q[Old] && rd_ena_q[Old] && (rd_addr_q[Old] != '0) && !stall_i;

    always_comb begin
        w_addr_o = '0;
        w_data_o = '0;
        if (valid_q[Old]) begin
            w_addr_o = rd_addr_q[Old];
            w_data_o = rd_data_q[Old];
        end
    end

    always_comb begin
        occupancy_o = '0;
        for (int k = 0; k < int'(STAGES); k++) begin
            occupancy_o = occupancy_o + 4'(valid_q[k]);
        end
    end

    // Scan oldest to youngest so the youngest match wins by overwriting.
    always_comb begin
        fwd_hit_o  = '0;
        fwd_data_o = '0;
        for (int j = 0; j < int'(NUM_RD); j++) begin
            for (int k = int'(STAGES) - 1; k >= 0; k--) begin
                if (valid_q[k] && rd_ena_q[k]
                    && (rs_addr_i[j*ADDR_W +: ADDR_W] != '0)
                    && (rd_addr_q[k] == rs_addr_i[j*ADDR_W +: ADDR_W])) begin
                    fwd_hit_o[j]                   = 1'b1;
                    fwd_data_o[j*DATA_W +: DATA_W] = rd_data_q[k];
                end
            end
        end
    end

endmodule
